// File: rtl/output_queue_pkg.sv
// Shared definitions for the output queue: pitch-shifter-wide default widths
// (kept identical to input_queue and the FFT cores) and the read FSM encoding.
package output_queue_pkg;

    // Pitch-shifter-wide defaults (pitch_shifter_defs)
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FRAME_LEN  = 1024;
    localparam int DEF_PWM_W      = 8;
    localparam int DEF_SAMPLE_DIV = 2083;

    // Read FSM encoding
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_PLAY = 1'b1;

endpackage

// File: rtl/output_queue_sample_buffer.sv
// Simple dual-port sample RAM holding both ping-pong banks. The bank is the
// address MSB; the read port is registered (one clock of latency).
module sample_buffer #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port
    // NOTE: storage and its read register have no reset; a reset cannot clear
    // a RAM macro, and bank full/free flags already mark which contents are valid.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/output_queue.sv
// Output queue: collects IFFT time-domain frames into two ping-pong banks and
// plays them out at the audio sample rate as a PWM stream.
module output_queue
    import output_queue_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int PWM_W      = DEF_PWM_W,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ifft_data,
    input  logic              ifft_valid,
    input  logic              ifft_last,
    output logic              ifft_ready,
    output logic              aud_pwm,
    output logic              aud_sd,
    output logic              underrun,
    output logic              frame_error
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CNT_W = $clog2(SAMPLE_DIV + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [PWM_W-1:0] MIDSCALE = {1'b1, {(PWM_W - 1){1'b0}}};

    logic              run;
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [0:0]        state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [PWM_W-1:0]  duty;
    logic              load_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] offset_sample;
    logic              unused_lsbs;

    logic accept;
    logic frame_done;
    logic tick;
    logic play_load;
    logic bank_release;

    // Handshake: ready only once out of reset and while the write bank is free.
    assign ifft_ready = run & ~full[wr_bank];
    assign accept     = ifft_valid & ifft_ready;
    assign frame_done = accept & (wr_idx == LAST_IDX);

    // A tick loads a sample while playing, and also on the tick that starts
    // playback, so the first sample goes out on the very tick that finds data.
    assign tick         = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign play_load    = tick & ((state == R_PLAY) | full[rd_bank]);
    assign bank_release = play_load & (rd_idx == LAST_IDX);

    // Offset-binary view of the RAM output: invert the sign bit.
    assign offset_sample = {~rd_data[DATA_W-1], rd_data[DATA_W-2:0]};
    assign unused_lsbs   = ^offset_sample[DATA_W-PWM_W-1:0];

    sample_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W + 1)
    ) u_buffer (
        .clock (clock),
        .we    (accept),
        .waddr ({wr_bank, wr_idx}),
        .wdata (ifft_data),
        .re    (play_load),
        .raddr ({rd_bank, rd_idx}),
        .rdata (rd_data)
    );

    // Enable the input handshake from the first clock after reset.
    // NOTE: every clocked register uses non-blocking assignments so all state
    // updates see the pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Write side: index tracking, frame commit and frame-length errors.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank     <= 1'b0;
            wr_idx      <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (accept) begin
                if (wr_idx == LAST_IDX) begin
                    // Full frame (or overlong): commit and move to the other bank.
                    wr_bank     <= ~wr_bank;
                    wr_idx      <= '0;
                    frame_error <= ~ifft_last;
                end else if (ifft_last) begin
                    // Short frame: drop it and refill the same bank.
                    wr_idx      <= '0;
                    frame_error <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    // Bank flags: the writer marks a bank full, the reader frees it. They never
    // target the same bank in one cycle since the writer only uses a free bank.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (frame_done && (wr_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (bank_release && (rd_bank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Read FSM: steps through the read bank one sample per tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= R_IDLE;
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            underrun <= 1'b0;
            aud_sd   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (play_load) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
            if ((state == R_IDLE) && play_load) begin
                state  <= R_PLAY;
                aud_sd <= 1'b1;
            end
            // Starved: the bank just finished and the other one is not ready.
            if (bank_release && !full[~rd_bank]) begin
                underrun <= 1'b1;
                state    <= R_IDLE;
            end
        end
    end

    // Free-running sample-rate divider.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Duty register: takes the RAM output one clock after the tick, else
    // rests at midscale while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_q <= 1'b0;
            duty   <= MIDSCALE;
        end else begin
            load_q <= play_load;
            if (load_q) begin
                duty <= offset_sample[DATA_W-1 -: PWM_W];
            end else if (state == R_IDLE) begin
                duty <= MIDSCALE;
            end
        end
    end

    // PWM generator with a registered output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            aud_pwm <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            aud_pwm <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_output_queue.sv
// Scoreboard bench for output_queue: the stimulus pushes the duty each played
// sample should produce; a monitor pops and compares on every duty update.
module tb_output_queue;
    import output_queue_pkg::*;

    localparam int DATA_W     = 12;
    localparam int FRAME_LEN  = 8;
    localparam int PWM_W      = 4;
    localparam int SAMPLE_DIV = 16;

    logic              clock;
    logic              reset_n;
    logic [DATA_W-1:0] ifft_data;
    logic              ifft_valid;
    logic              ifft_last;
    logic              ifft_ready;
    logic              aud_pwm;
    logic              aud_sd;
    logic              underrun;
    logic              frame_error;

    output_queue #(
        .DATA_W     (DATA_W),
        .FRAME_LEN  (FRAME_LEN),
        .PWM_W      (PWM_W),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ifft_data   (ifft_data),
        .ifft_valid  (ifft_valid),
        .ifft_last   (ifft_last),
        .ifft_ready  (ifft_ready),
        .aud_pwm     (aud_pwm),
        .aud_sd      (aud_sd),
        .underrun    (underrun),
        .frame_error (frame_error)
    );

    // Directed frames and their hand-computed duties (top 4 bits, sign inverted).
    logic [DATA_W-1:0] frames [3][8] = '{
        '{12'h800, 12'h000, 12'h7FF, 12'h400, 12'hC00, 12'h123, 12'hFFF, 12'h001},
        '{12'h100, 12'h200, 12'h300, 12'h500, 12'h600, 12'h700, 12'h900, 12'hA00},
        '{12'hF00, 12'hE00, 12'hD00, 12'hB00, 12'h080, 12'h0F0, 12'h8FF, 12'h7F0}
    };
    logic [PWM_W-1:0] duties [3][8] = '{
        '{4'd0,  4'd8,  4'd15, 4'd12, 4'd4,  4'd9,  4'd7, 4'd8},
        '{4'd9,  4'd10, 4'd11, 4'd13, 4'd14, 4'd15, 4'd1, 4'd2},
        '{4'd7,  4'd6,  4'd5,  4'd3,  4'd8,  4'd8,  4'd0, 4'd15}
    };

    logic [PWM_W-1:0] sb [$];
    int n_checks      = 0;
    int n_fail        = 0;
    int underrun_cnt  = 0;
    int frame_err_cnt = 0;
    int played        = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: counts pulses and compares the duty one clock after each load.
    initial begin : monitor
        logic pending;
        pending = 1'b0;
        forever begin
            @(negedge clock);
            if (underrun) underrun_cnt++;
            if (frame_error) frame_err_cnt++;
            if (pending && reset_n) begin
                if (sb.size() == 0) begin
                    check("unexpected_duty_update", 1, 0);
                end else begin
                    check("duty", int'(dut.duty), int'(sb.pop_front()));
                    played++;
                end
            end
            pending = reset_n && dut.load_q;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        ifft_valid = 1'b0;
        ifft_last  = 1'b0;
        ifft_data  = '0;
        reset_n    = 1'b0;
        sb.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Present one beat (valid stays asserted afterwards) and wait for its transfer.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
        int waited;
        waited     = 0;
        ifft_data  = d;
        ifft_last  = l;
        ifft_valid = 1'b1;
        while (!ifft_ready && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        check("beat_accept_timeout", int'(ifft_ready), 1);
        @(negedge clock);
    endtask

    task automatic send_frame(input int f, input int n, input int last_pos, input bit push);
        for (int i = 0; i < n; i++) begin
            send_beat(frames[f][i], i == last_pos);
            if (push) sb.push_back(duties[f][i]);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clock);
            c++;
        end
        repeat (4) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin : stimulus
        int u0, f0, p0, highs, found;
        logic prev_end;

        // Reset values and release behaviour
        reset_n    = 1'b0;
        ifft_valid = 1'b0;
        ifft_last  = 1'b0;
        ifft_data  = '0;
        repeat (2) @(negedge clock);
        check("rst_ifft_ready", int'(ifft_ready), 0);
        check("rst_aud_pwm", int'(aud_pwm), 0);
        check("rst_aud_sd", int'(aud_sd), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_frame_error", int'(frame_error), 0);
        check("rst_duty", int'(dut.duty), 8);
        reset_n = 1'b1;
        #1;
        check("ready_before_first_clock", int'(ifft_ready), 0);
        @(negedge clock);
        check("ready_first_clock", int'(ifft_ready), 1);

        // One frame, then starvation
        u0 = underrun_cnt; f0 = frame_err_cnt; p0 = played;
        send_frame(0, 8, 7, 1'b1);
        ifft_valid = 1'b0;
        check("aud_sd_before_play", int'(aud_sd), 0);
        wait_drain(400);
        check("aud_sd_after_play", int'(aud_sd), 1);
        check("t1_played", played - p0, 8);
        check("t1_underrun_once", underrun_cnt - u0, 1);
        check("t1_no_frame_error", frame_err_cnt - f0, 0);
        check("t1_duty_midscale", int'(dut.duty), 8);
        highs = 0;
        repeat (32) begin
            @(negedge clock);
            if (aud_pwm) highs++;
        end
        check("t1_pwm_50pct_highs", highs, 16);

        // Three back-to-back frames with valid held
        do_reset();
        u0 = underrun_cnt; p0 = played;
        send_frame(0, 8, 7, 1'b1);
        send_frame(1, 8, 7, 1'b1);
        check("t2_ready_low_after_16", int'(ifft_ready), 0);
        found = 0; prev_end = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (ifft_ready) begin
                found = 1;
                break;
            end
            prev_end = dut.tick && (dut.state == R_PLAY) && !dut.rd_bank && (dut.rd_idx == 3'd7);
        end
        check("t2_ready_rises", found, 1);
        check("t2_ready_after_bank0_done", int'(prev_end), 1);
        send_frame(2, 8, 7, 1'b1);
        ifft_valid = 1'b0;
        wait_drain(1000);
        check("t2_played", played - p0, 24);
        check("t2_underrun_only_at_end", underrun_cnt - u0, 1);

        // Short frame: last on beat 4 is discarded
        do_reset();
        u0 = underrun_cnt; f0 = frame_err_cnt; p0 = played;
        send_frame(2, 5, 4, 1'b0);
        send_frame(0, 8, 7, 1'b1);
        ifft_valid = 1'b0;
        wait_drain(600);
        check("t3_frame_error", frame_err_cnt - f0, 1);
        check("t3_played", played - p0, 8);
        check("t3_underrun", underrun_cnt - u0, 1);

        // Long frame: no last on beat 7 still plays, next frame follows
        do_reset();
        u0 = underrun_cnt; f0 = frame_err_cnt; p0 = played;
        send_frame(1, 8, -1, 1'b1);
        send_frame(2, 8, 7, 1'b1);
        ifft_valid = 1'b0;
        wait_drain(800);
        check("t4_frame_error", frame_err_cnt - f0, 1);
        check("t4_played", played - p0, 16);
        check("t4_underrun", underrun_cnt - u0, 1);

        // Reset mid-playback
        do_reset();
        p0 = played;
        send_frame(0, 8, 7, 1'b1);
        ifft_valid = 1'b0;
        for (int c = 0; c < 400 && (played - p0) < 3; c++) @(negedge clock);
        check("t5_reached_playback", played - p0, 3);
        u0 = underrun_cnt; f0 = frame_err_cnt;
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("t5_ifft_ready", int'(ifft_ready), 0);
        check("t5_aud_pwm", int'(aud_pwm), 0);
        check("t5_aud_sd", int'(aud_sd), 0);
        check("t5_underrun", int'(underrun), 0);
        check("t5_frame_error", int'(frame_error), 0);
        check("t5_duty", int'(dut.duty), 8);
        repeat (10) @(negedge clock);
        reset_n = 1'b1;
        repeat (200) @(negedge clock);
        check("t5_no_underrun_pulse", underrun_cnt - u0, 0);
        check("t5_no_frame_error_pulse", frame_err_cnt - f0, 0);
        check("t5_aud_sd_stays_off", int'(aud_sd), 0);
        check("t5_ready_after_reset", int'(ifft_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_queue.md
OUTPUT_QUEUE -- requirements
Module: output_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning the signed sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 1024, meaning samples per frame; must be a power of two.
REQ-003 SHALL have parameter PWM_W, default 8, meaning PWM duty resolution in bits.
REQ-004 SHALL have parameter SAMPLE_DIV, default 2083, meaning clocks per output sample (100 MHz to about 48 kHz).
REQ-005 SHALL have port clock, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port ifft_data, input, DATA_W bits: signed real-part time-domain sample.
REQ-008 SHALL have port ifft_valid, input, 1 bit: ifft_data is valid this cycle.
REQ-009 SHALL have port ifft_last, input, 1 bit: this beat is the final beat of a frame.
REQ-010 SHALL have port ifft_ready, output, 1 bit: this block accepts a beat this cycle.
REQ-011 SHALL have port aud_pwm, output, 1 bit: PWM audio output.
REQ-012 SHALL have port aud_sd, output, 1 bit: audio amplifier enable, 1 = on.
REQ-013 SHALL have port underrun, output, 1 bit: one-cycle pulse when playback starves.
REQ-014 SHALL have port frame_error, output, 1 bit: one-cycle pulse on a frame-length mismatch.

Function
REQ-015 SHALL buffer samples in two FRAME_LEN-deep banks (ping-pong), each flagged full or free.
REQ-016 SHALL transfer a beat only when ifft_valid and ifft_ready are both 1 in the same cycle.
REQ-017 SHALL drive ifft_ready to 1 only while the current write bank is free.
REQ-018 SHALL write each accepted sample into the write bank at write index wr_idx, then increment wr_idx.
REQ-019 SHALL, when ifft_last is 1 on beat wr_idx = FRAME_LEN-1, mark the bank full, toggle the write bank and clear wr_idx.
REQ-020 SHALL, when ifft_last is 1 with wr_idx < FRAME_LEN-1 (short frame), pulse frame_error, discard the partial bank and clear wr_idx on the same bank.
REQ-021 SHALL, when ifft_last is 0 on beat wr_idx = FRAME_LEN-1 (long frame), pulse frame_error and still commit the bank as in REQ-019; the next beat starts a new frame.
REQ-022 SHALL generate a sample tick every SAMPLE_DIV clocks from a free-running counter.
REQ-023 SHALL implement a read FSM with two states:
- R_IDLE -> R_PLAY on a tick when the read bank is full.
- In R_PLAY, each tick loads the sample at rd_idx and increments rd_idx.
- After index FRAME_LEN-1 is loaded, the bank is marked free and the read bank toggles.
- If the new read bank is not full: pulse underrun and go to R_IDLE.
REQ-024 SHALL give the RAM read one clock of latency, so the loaded sample updates the duty register on the cycle after the tick.
REQ-025 SHALL form duty as the top PWM_W bits of the offset-binary sample (sample MSB inverted).
REQ-026 SHALL hold duty at 2^(PWM_W-1) (midscale) while in R_IDLE.
REQ-027 SHALL run a free-running PWM_W-bit counter and drive aud_pwm to 1 while counter < duty, registered.
REQ-028 SHALL drive aud_sd to 0 until the first R_IDLE to R_PLAY transition, then hold it at 1 until reset.
REQ-029 SHALL make a bank freed by the read side (REQ-023) writable on the next cycle, including when a write attempt to that bank occurs in the same cycle.

Reset
REQ-030 SHALL, while reset_n is 0, force:
- both banks free, write bank 0, read bank 0, wr_idx = 0, rd_idx = 0;
- FSM = R_IDLE;
- tick counter and PWM counter = 0;
- duty = midscale;
- outputs ifft_ready = 0, aud_pwm = 0, aud_sd = 0, underrun = 0, frame_error = 0.
REQ-031 SHALL drive ifft_ready to 1 on the first clock after reset_n rises.
REQ-032 SHALL, on reset mid-frame or mid-playback, abandon all buffered data without further output pulses.

Structure
REQ-033 SHALL take the defaults for DATA_W and FRAME_LEN from the shared pitch_shifter_defs header so they match input_queue and the FFT cores.
REQ-034 SHALL place the storage in one sub-module, sample_buffer: a simple dual-port RAM of 2*FRAME_LEN x DATA_W, with bank selected by the address MSB and a registered read.

Verification
Bench parameters: FRAME_LEN = 8, SAMPLE_DIV = 16, PWM_W = 4, DATA_W = 12.
REQ-035 SHALL check: frame 0x800,0x000,0x7FF,... with last on beat 7 -> first tick after reset plays it; duties read 0, 8, 15; aud_sd rises with the first play.
REQ-036 SHALL check: three back-to-back frames with ifft_valid held at 1 -> ifft_ready falls after 16 beats and rises one cycle after bank 0 finishes playing; no underrun.
REQ-037 SHALL check: one frame then no input -> underrun pulses once after 8 ticks; duty returns to 8; aud_pwm duty cycle is 50%.
REQ-038 SHALL check: ifft_last on beat 4 -> frame_error pulses; that bank is not played; the next full frame plays normally.
REQ-039 SHALL check: no ifft_last on beat 7 -> frame_error pulses and the frame still plays.
REQ-040 SHALL check: reset_n dropped mid-playback -> all outputs reach their reset values immediately, with no pulse on underrun or frame_error.
